// File: rtl/instr_fetch_if.sv
// Bundles the instruction-memory read port, the decode valid/ready handshake
// and the execute-side redirect/halt controls of the simpleCPU fetch unit.
`timescale 1ns/1ps

interface instr_fetch_if #(
    parameter int ADDR_W = 12
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic [15:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              resume;
    logic              halted;

    modport master (
        output imem_en, imem_addr, instr, instr_pc, instr_valid, halted,
        input  imem_rdata, instr_ready, redirect, redirect_pc, halt, resume
    );

    modport slave (
        input  imem_en, imem_addr, instr, instr_pc, instr_valid, halted,
        output imem_rdata, instr_ready, redirect, redirect_pc, halt, resume
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the fetch PC, reads a synchronous instruction
// memory and feeds decode through a 2-entry (head + skid) buffer.
`timescale 1ns/1ps

module instr_fetch #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    instr_fetch_if.master   bus
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_e;

    state_e            state_q,       state_d;
    logic [ADDR_W-1:0] fetch_pc_q,    fetch_pc_d;
    logic [15:0]       instr_q,       instr_d;
    logic [ADDR_W-1:0] pc_q,          pc_d;
    logic [15:0]       skid_instr_q,  skid_instr_d;
    logic [ADDR_W-1:0] skid_pc_q,     skid_pc_d;
    logic [1:0]        occ_q,         occ_d;
    logic              inflight_q,    inflight_d;
    logic              stale_q,       stale_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic       pop;
    logic       halt_pop;
    logic       flush;
    logic       issue;
    logic       accept;
    logic [1:0] occ_left;

    always_comb begin
        // NOTE: every variable written here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        occ_d         = occ_q;
        inflight_pc_d = inflight_pc_q;

        pop      = (occ_q != 2'd0) & bus.instr_ready;
        halt_pop = (state_q == S_RUN) & pop & bus.halt;
        flush    = bus.redirect | halt_pop;
        occ_left = occ_q - {1'b0, pop};

        // The in-flight response lands next cycle, so it already owns an entry.
        issue  = reset & (state_q == S_RUN) & ~bus.redirect &
                 (({1'b0, occ_left} + {2'b00, inflight_q}) < 3'd2);
        accept = (state_q == S_RUN) & inflight_q & ~stale_q & ~flush;

        inflight_d = issue;
        stale_d    = issue & flush;
        if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
        end

        if (state_q == S_RUN) begin
            if (bus.redirect) begin
                occ_d      = 2'd0;
                fetch_pc_d = bus.redirect_pc;
            end else if (halt_pop) begin
                occ_d      = 2'd0;
                fetch_pc_d = pc_q + ADDR_W'(1);
                state_d    = S_HALT;
            end else begin
                if (pop && occ_q == 2'd2) begin
                    instr_d = skid_instr_q;
                    pc_d    = skid_pc_q;
                end
                occ_d = occ_left;
                if (accept) begin
                    if (occ_left == 2'd0) begin
                        instr_d = bus.imem_rdata;
                        pc_d    = inflight_pc_q;
                    end else begin
                        skid_instr_d = bus.imem_rdata;
                        skid_pc_d    = inflight_pc_q;
                    end
                    occ_d = occ_left + 2'd1;
                end
            end
        end else begin
            if (bus.redirect) begin
                fetch_pc_d = bus.redirect_pc;
            end
            if (bus.resume) begin
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the values from before this edge.
        if (!reset) begin
            state_q       <= S_RUN;
            fetch_pc_q    <= RESET_PC;
            instr_q       <= '0;
            pc_q          <= '0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
            occ_q         <= 2'd0;
            inflight_q    <= 1'b0;
            stale_q       <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            occ_q         <= occ_d;
            inflight_q    <= inflight_d;
            stale_q       <= stale_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign bus.imem_en     = issue;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = pc_q;
    assign bus.instr_valid = (occ_q != 2'd0);
    assign bus.halted      = (state_q == S_HALT);

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the 16-bit simpleCPU: the producer side of the instruction interface that the combinational decoder consumes. It owns the fetch PC and reads a synchronous instruction memory. It presents one 16-bit instruction at a time to decode over a valid/ready handshake. It honours branch/jump redirects from execute and halt/resume requests.

## Interface
- ADDR_W, 12: width of the instruction address / PC.
- RESET_PC, 0: first fetch address after reset.

- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low; held low clears all state.
- imem_en  output  1  read request to instruction memory this cycle.
- imem_addr  output  ADDR_W  read address; sampled by memory when imem_en=1.
- imem_rdata  input  16  read data, valid exactly one cycle after the request.
- instr  output  16  instruction word to decoder (registered).
- instr_pc  output  ADDR_W  address `instr` was fetched from (for PC-relative branch math).
- instr_valid  output  1  `instr`/`instr_pc` hold a live instruction.
- instr_ready  input  1  decoder accepts; transfer when instr_valid & instr_ready.
- redirect  input  1  taken branch/jump; flush and restart at redirect_pc.
- redirect_pc  input  ADDR_W  new fetch address, sampled when redirect=1.
- halt  input  1  the instruction being transferred this cycle decodes as HALT.
- resume  input  1  leave HALT state and continue fetching.
- halted  output  1  unit is in HALT state.

## Operation
- States: RUN, HALT. Reset enters RUN with fetch_pc=RESET_PC.
- Buffer: 2 entries {instr, pc}. The output register is the head; one skid entry sits behind it. occ = 0..2.
- In-flight: at most 1 request. The inflight flag is set the cycle imem_en=1. The response is written next cycle into the first free entry. A response with its stale flag set is discarded.
- Issue rule in RUN: imem_en=1 iff no redirect this cycle and (occ − pop) + inflight < 2, where pop = instr_valid & instr_ready. On issue, imem_addr=fetch_pc and fetch_pc increments by 1, wrapping modulo 2^ADDR_W.
- Pop: skid moves to head in the same edge. instr_valid=1 iff occ>0.
- redirect=1: clear both entries (occ=0), mark any in-flight response stale, set fetch_pc=redirect_pc. No issue this cycle; the first request from redirect_pc goes out the next cycle.
- halt=1 with pop=1 in RUN: enter HALT. Set fetch_pc = halted instr_pc + 1, clear buffer, mark in-flight stale. halt with pop=0 is ignored.
- HALT: imem_en=0, instr_valid=0, halted=1. resume=1 returns to RUN; issue starts the following cycle from fetch_pc.
- Simultaneous events:
  - redirect and halt-pop in the same cycle: redirect wins and state stays RUN.
  - redirect in HALT: fetch_pc=redirect_pc and the unit stays halted.
  - redirect+resume in HALT: RUN from redirect_pc.
  - resume in RUN: ignored.
- Instruction 0x0000 (NOP) gets no special handling.

## Timing
- Reset (reset=0 at edge) sets:
  - Outputs: imem_en=0, imem_addr=RESET_PC, instr=16'h0000, instr_pc=0, instr_valid=0, halted=0.
  - Internal state: occ=0, inflight=0, stale=0.
- First cycle with reset=1 (cycle 0): imem_en=1, imem_addr=RESET_PC.
- Latency: request in cycle t, instr_valid in cycle t+2 when the buffer is empty.
- Throughput: with instr_ready held high, one instruction per cycle after the 2-cycle fill.
- Backpressure: instr/instr_pc are stable while instr_valid=1 and instr_ready=0. No entry is ever overwritten or dropped. imem_en stays 0 while occ+inflight=2.
- Redirect: redirect at cycle t gives request from redirect_pc at t+1 and instr_valid at t+3. No stale instruction is visible at any cycle ≥ t+1.
- HALT: halted=1 from the cycle after the halt-pop. resume at cycle t gives imem_en at t+1.
- Reset asserted mid-operation overrides everything, including a stale in-flight response. That response arrives during or after reset and is ignored.

## Test plan
- Streaming: memory holds 0x4001,0x4002,…; ready=1. Required: instr_valid from cycle 2, instr_pc=0,1,2,… consecutively, one per cycle, imem_addr 0,1,2,…
- Backpressure: drop ready for 3 cycles mid-stream. Required: instr held constant, at most 2 requests ahead, no duplicate or lost pc after ready returns.
- Redirect: redirect=1, redirect_pc=0x080 while a request is in flight. Required: the in-flight word is never presented, next instr_pc=0x080 exactly 3 cycles later.
- Halt/resume: accept word at pc 0x010 with halt=1. Required: halted=1 next cycle, imem_en=0 during HALT. After resume, the next instr_pc=0x011.
- Wrap/concurrency:
  - fetch_pc=0xFFF: next fetch address is 0x000.
  - redirect+halt same cycle: stays RUN at redirect_pc.
- Reset mid-stream: reset=0 for 1 cycle with occ=2 and inflight=1. Required: all outputs at reset values, restart at RESET_PC, no pre-reset instruction visible.
